// File: rtl/switch_pwr_pkg.sv
// switch_pwr_pkg: shared state encoding and default ms timings for the switch power-down sequencer
package switch_pwr_pkg;
    typedef enum logic [2:0] {
        ST_ON       = 3'd0,
        ST_PRST_LOW = 3'd1,
        ST_RST_LOW  = 3'd2,
        ST_OFF_0V8  = 3'd3,
        ST_OFF_1V8  = 3'd4,
        ST_OFF      = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;
    localparam int DEF_T_PRST_MS     = 10;
    localparam int DEF_T_RST_MS      = 20;
    localparam int DEF_PG_TIMEOUT_MS = 100;
    localparam int DEF_CNT_W         = 9;
endpackage

// File: rtl/switch_pwr_ms_timer.sv
// switch_pwr_ms_timer: saturating millisecond counter, cleared on demand
module switch_pwr_ms_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clock) begin
        if (reset || clear) r_cnt <= '0;
        else if (tick && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
    assign count = r_cnt;
endmodule

// File: rtl/switch_power_down_control.sv
// switch_power_down_control: orderly PCIe switch power-down sequencer emitting active-high permit gates
module switch_power_down_control
    import switch_pwr_pkg::*;
#(
    parameter int T_PRST_MS     = DEF_T_PRST_MS,
    parameter int T_RST_MS      = DEF_T_RST_MS,
    parameter int PG_TIMEOUT_MS = DEF_PG_TIMEOUT_MS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic int_1ms_en,
    input  logic pwr_off_req,
    input  logic pg_pcie_sw_0v8_a,
    input  logic pg_pcie_sw_0v8_b,
    input  logic pg_vdd_1v8,
    output logic prst_permit,
    output logic sys_rst_permit,
    output logic en_0v8_permit,
    output logic en_1v8_permit,
    output logic pwr_off_done,
    output logic pwr_fault
);
    localparam logic [CNT_W-1:0] L_PRST = CNT_W'(T_PRST_MS);
    localparam logic [CNT_W-1:0] L_RST  = CNT_W'(T_RST_MS);
    localparam logic [CNT_W-1:0] L_PGTO = CNT_W'(PG_TIMEOUT_MS);

    logic [3:0]       r_s1, r_s2;
    state_t           r_state, w_next;
    logic             r_armed;
    logic             r_prst, r_sys, r_en0v8, r_en1v8, r_done, r_fault;
    logic [CNT_W-1:0] w_cnt;
    logic             w_req, w_pg_a, w_pg_b, w_pg_1v8, w_pg_0v8;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {pwr_off_req, pg_pcie_sw_0v8_a, pg_pcie_sw_0v8_b, pg_vdd_1v8};
            r_s2 <= r_s1;
        end
    end
    assign {w_req, w_pg_a, w_pg_b, w_pg_1v8} = r_s2;
    assign w_pg_0v8 = w_pg_a & w_pg_b;

    switch_pwr_ms_timer #(.CNT_W(CNT_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (w_next != r_state),
        .tick  (int_1ms_en),
        .count (w_cnt)
    );

    // A power-good falling wins over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ON:       w_next = w_req ? ST_PRST_LOW : (r_armed && !w_pg_0v8) ? ST_FAULT : ST_ON;
            ST_PRST_LOW: w_next = (w_cnt == L_PRST) ? ST_RST_LOW : ST_PRST_LOW;
            ST_RST_LOW:  w_next = (w_cnt == L_RST) ? ST_OFF_0V8 : ST_RST_LOW;
            ST_OFF_0V8:  w_next = (!w_pg_a && !w_pg_b) ? ST_OFF_1V8 : (w_cnt == L_PGTO) ? ST_FAULT : ST_OFF_0V8;
            ST_OFF_1V8:  w_next = !w_pg_1v8 ? ST_OFF : (w_cnt == L_PGTO) ? ST_FAULT : ST_OFF_1V8;
            ST_OFF:      w_next = w_req ? ST_OFF : ST_ON;
            default:     w_next = ST_FAULT;
        endcase
    end

    // Permits decode from the next state so they move with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_ON;
            r_armed <= 1'b0;
            r_prst  <= 1'b1;
            r_sys   <= 1'b1;
            r_en0v8 <= 1'b1;
            r_en1v8 <= 1'b1;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= (r_state == ST_ON && w_next == ST_ON) ? (r_armed | w_pg_0v8) : 1'b0;
            r_prst  <= w_next == ST_ON;
            r_sys   <= w_next <= ST_PRST_LOW;
            r_en0v8 <= w_next <= ST_RST_LOW;
            r_en1v8 <= w_next <= ST_OFF_0V8;
            r_done  <= w_next == ST_OFF;
            r_fault <= w_next == ST_FAULT;
        end
    end

    assign prst_permit    = r_prst;
    assign sys_rst_permit = r_sys;
    assign en_0v8_permit  = r_en0v8;
    assign en_1v8_permit  = r_en1v8;
    assign pwr_off_done   = r_done;
    assign pwr_fault      = r_fault;
endmodule

// File: tb/tb_switch_power_down_control.sv
// tb_switch_power_down_control: directed checks of the power-down sequence, timeouts and fault latching
module tb_switch_power_down_control;
    logic clock = 1'b0;
    logic reset, int_1ms_en, pwr_off_req, pg_a, pg_b, pg_1v8;
    logic prst, sys, en0, en1, done, fault;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    int   tick_div = 0;

    switch_power_down_control dut (
        .clock            (clock),
        .reset            (reset),
        .int_1ms_en       (int_1ms_en),
        .pwr_off_req      (pwr_off_req),
        .pg_pcie_sw_0v8_a (pg_a),
        .pg_pcie_sw_0v8_b (pg_b),
        .pg_vdd_1v8       (pg_1v8),
        .prst_permit      (prst),
        .sys_rst_permit   (sys),
        .en_0v8_permit    (en0),
        .en_1v8_permit    (en1),
        .pwr_off_done     (done),
        .pwr_fault        (fault)
    );

    always #5 clock = ~clock;

    initial int_1ms_en = 1'b0;
    always @(posedge clock) begin
        #1;
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        int_1ms_en = (tick_div == 9);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    function automatic logic pick(input int sel);
        return sel == 0 ? prst : sel == 1 ? sys : sel == 2 ? en0 : sel == 3 ? en1 : sel == 4 ? done : fault;
    endfunction

    // Steps one cycle at a time until the selected output reaches val; n is edges taken
    task automatic wait_for(input int sel, input logic val, input int lim, output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (pick(sel) != val && cnt <= lim);
    endtask

    initial begin
        reset = 1'b1; pwr_off_req = 1'b0; pg_a = 1'b1; pg_b = 1'b1; pg_1v8 = 1'b1;
        cyc(2);
        check("rst_prst", prst, 1);
        check("rst_sys", sys, 1);
        check("rst_en0v8", en0, 1);
        check("rst_en1v8", en1, 1);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        reset = 1'b0;
        cyc(5);
        check("on_fault_idle", fault, 0);

        pwr_off_req = 1'b1;
        cyc(2);
        check("prst_lat2", prst, 1);
        cyc(1);
        check("prst_lat3", prst, 0);
        check("sys_in_prst", sys, 1);
        wait_for(1, 1'b0, 150, n);
        check($sformatf("sys_dwell n=%0d", n), int'(n >= 92 && n <= 101), 1);
        wait_for(2, 1'b0, 250, n);
        check($sformatf("en0v8_dwell n=%0d", n), int'(n >= 192 && n <= 201), 1);
        check("en1v8_in_off0v8", en1, 1);
        cyc(50);
        pg_a = 1'b0; pg_b = 1'b0;
        cyc(2);
        check("en1v8_lat2", en1, 1);
        cyc(1);
        check("en1v8_lat3", en1, 0);
        cyc(30);
        pg_1v8 = 1'b0;
        cyc(2);
        check("done_lat2", done, 0);
        cyc(1);
        check("done_lat3", done, 1);
        check("done_fault", fault, 0);
        check("done_prst", prst, 0);
        check("done_en0v8", en0, 0);

        pwr_off_req = 1'b0;
        cyc(2);
        check("ret_done_lat2", done, 1);
        cyc(1);
        check("ret_done", done, 0);
        check("ret_prst", prst, 1);
        check("ret_sys", sys, 1);
        check("ret_en0v8", en0, 1);
        check("ret_en1v8", en1, 1);

        pg_a = 1'b1; pg_b = 1'b1; pg_1v8 = 1'b1;
        cyc(5);
        pwr_off_req = 1'b1;
        wait_for(1, 1'b0, 150, n);
        check("mid_sys", sys, 0);
        cyc(20);
        pwr_off_req = 1'b0;
        wait_for(2, 1'b0, 250, n);
        check("mid_en0v8", en0, 0);
        cyc(10);
        pg_a = 1'b0; pg_b = 1'b0;
        wait_for(3, 1'b0, 20, n);
        check("mid_en1v8", en1, 0);
        cyc(10);
        pg_1v8 = 1'b0;
        wait_for(4, 1'b1, 20, n);
        check("mid_done", done, 1);
        cyc(1);
        check("mid_back_done", done, 0);
        check("mid_back_prst", prst, 1);
        check("mid_back_fault", fault, 0);

        pg_a = 1'b1; pg_b = 1'b1; pg_1v8 = 1'b1;
        cyc(5);
        pwr_off_req = 1'b1;
        wait_for(2, 1'b0, 400, n);
        check("rsq_en0v8", en0, 0);
        cyc(5);
        reset = 1'b1;
        cyc(1);
        check("rsq_prst", prst, 1);
        check("rsq_sys", sys, 1);
        check("rsq_en0v8_back", en0, 1);
        check("rsq_en1v8", en1, 1);
        check("rsq_fault", fault, 0);
        reset = 1'b0; pwr_off_req = 1'b0;
        cyc(5);

        pwr_off_req = 1'b1;
        wait_for(2, 1'b0, 400, n);
        check("to_en0v8", en0, 0);
        pg_a = 1'b0;
        wait_for(5, 1'b1, 1100, n);
        check($sformatf("to_dwell n=%0d", n), int'(n >= 992 && n <= 1001), 1);
        check("to_en1v8", en1, 0);
        check("to_done", done, 0);
        cyc(50);
        check("to_sticky", fault, 1);
        pg_b = 1'b0;
        reset = 1'b1;
        cyc(1);
        check("to_reset_fault", fault, 0);
        reset = 1'b0; pwr_off_req = 1'b0;

        pg_a = 1'b1;
        cyc(5);
        pg_a = 1'b0;
        cyc(5);
        check("unarmed_fault", fault, 0);
        check("unarmed_prst", prst, 1);

        pg_a = 1'b1; pg_b = 1'b1;
        cyc(5);
        pg_a = 1'b0;
        cyc(2);
        check("armed_lat2", fault, 0);
        cyc(1);
        check("armed_fault", fault, 1);
        check("armed_prst", prst, 0);
        check("armed_sys", sys, 0);
        check("armed_en0v8", en0, 0);
        check("armed_en1v8", en1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
